// File: rtl/knockback_unit.sv
// Two-player attack sequencing, hit detection and knockback velocity generation.
// Everything advances once per frame_clk; every output comes from a register.
module knockback_unit #(
    parameter logic [7:0] P1_ATK_KEY      = 8'h09,
    parameter logic [7:0] P2_ATK_KEY      = 8'h10,
    parameter int         STARTUP_FRAMES  = 4,
    parameter int         ACTIVE_FRAMES   = 3,
    parameter int         RECOVERY_FRAMES = 8,
    parameter int         HIT_RANGE       = 150,
    parameter int         KB_FRAMES       = 8,
    parameter int         KB_SPEED        = 3,
    parameter int         INIT_DIST       = 320,
    parameter int         BOUND_X_MAX     = 635,
    parameter int         P2_EDGE         = 125
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode_0,
    input  logic [7:0] keycode_1,
    input  logic [7:0] keycode_2,
    input  logic [7:0] keycode_3,
    input  logic [9:0] RyuX,
    input  logic [9:0] AkumaX,
    input  logic       RyuJump,
    input  logic       AkumaJump,
    output int         XDist,
    output int         Ryu_Knockback,
    output int         Akuma_Knockback,
    output logic       RyuHit,
    output logic       AkumaHit,
    output logic       RyuAtkActive,
    output logic       AkumaAtkActive
);

    localparam int MAX_SU_AC = (STARTUP_FRAMES > ACTIVE_FRAMES) ? STARTUP_FRAMES : ACTIVE_FRAMES;
    localparam int MAX_PHASE = (MAX_SU_AC > RECOVERY_FRAMES) ? MAX_SU_AC : RECOVERY_FRAMES;
    localparam int CNT_W     = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
    localparam int KB_W      = $clog2(KB_FRAMES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STARTUP,
        ST_ACTIVE,
        ST_RECOVERY
    } atk_state_t;

    typedef struct packed {
        atk_state_t       state;
        logic [CNT_W-1:0] cnt;
    } phase_t;

    localparam phase_t PHASE_IDLE = '{state: ST_IDLE, cnt: '0};

    phase_t            ryu_phase_q, ryu_phase_d;
    phase_t            akuma_phase_q, akuma_phase_d;
    logic [KB_W-1:0]   ryu_kb_q, ryu_kb_d;
    logic [KB_W-1:0]   akuma_kb_q, akuma_kb_d;
    logic              ryu_conn_q, ryu_conn_d;
    logic              akuma_conn_q, akuma_conn_d;
    logic              ryu_pressed, akuma_pressed;
    logic              ryu_pressed_q, akuma_pressed_q;
    logic              ryu_trig, akuma_trig;
    logic              ryu_struck, akuma_struck;
    logic              in_range;
    logic              ryu_clamp, akuma_clamp;

    // Advance one attack FSM by a frame; each phase reloads its counter on entry.
    function automatic phase_t step_phase(input phase_t cur, input logic start);
        phase_t nxt;
        nxt = cur;
        case (cur.state)
            ST_IDLE: begin
                if (start) begin
                    nxt.state = ST_STARTUP;
                    nxt.cnt   = CNT_W'(STARTUP_FRAMES - 1);
                end
            end
            ST_STARTUP: begin
                if (cur.cnt == '0) begin
                    nxt.state = ST_ACTIVE;
                    nxt.cnt   = CNT_W'(ACTIVE_FRAMES - 1);
                end else begin
                    nxt.cnt = cur.cnt - 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cur.cnt == '0) begin
                    nxt.state = ST_RECOVERY;
                    nxt.cnt   = CNT_W'(RECOVERY_FRAMES - 1);
                end else begin
                    nxt.cnt = cur.cnt - 1'b1;
                end
            end
            ST_RECOVERY: begin
                if (cur.cnt == '0) begin
                    nxt = PHASE_IDLE;
                end else begin
                    nxt.cnt = cur.cnt - 1'b1;
                end
            end
            default: nxt = PHASE_IDLE;
        endcase
        return nxt;
    endfunction

    function automatic logic [KB_W-1:0] step_kb(input logic [KB_W-1:0] cur, input logic struck);
        logic [KB_W-1:0] nxt;
        if (struck) begin
            nxt = KB_W'(KB_FRAMES);
        end else if (cur != '0) begin
            nxt = cur - 1'b1;
        end else begin
            nxt = '0;
        end
        return nxt;
    endfunction

    assign ryu_pressed   = (keycode_0 == P1_ATK_KEY) || (keycode_1 == P1_ATK_KEY) ||
                           (keycode_2 == P1_ATK_KEY) || (keycode_3 == P1_ATK_KEY);
    assign akuma_pressed = (keycode_0 == P2_ATK_KEY) || (keycode_1 == P2_ATK_KEY) ||
                           (keycode_2 == P2_ATK_KEY) || (keycode_3 == P2_ATK_KEY);
    assign ryu_trig      = ryu_pressed && !ryu_pressed_q;
    assign akuma_trig    = akuma_pressed && !akuma_pressed_q;

    // Signed compare: a crossed-over pair (negative XDist) is still in range.
    assign in_range    = (XDist <= HIT_RANGE);
    assign akuma_clamp = (int'(AkumaX) + P2_EDGE + KB_SPEED) >= BOUND_X_MAX;
    assign ryu_clamp   = int'(RyuX) < KB_SPEED;

    // NOTE: every variable gets a default at the top of the block so no path leaves one unassigned and infers a latch.
    always_comb begin
        ryu_struck    = 1'b0;
        akuma_struck  = 1'b0;
        ryu_phase_d   = ryu_phase_q;
        akuma_phase_d = akuma_phase_q;
        ryu_conn_d    = ryu_conn_q;
        akuma_conn_d  = akuma_conn_q;

        if (akuma_phase_q.state == ST_ACTIVE && in_range && !RyuJump &&
            ryu_kb_q == '0 && !akuma_conn_q) begin
            ryu_struck = 1'b1;
        end
        if (ryu_phase_q.state == ST_ACTIVE && in_range && !AkumaJump &&
            akuma_kb_q == '0 && !ryu_conn_q) begin
            akuma_struck = 1'b1;
        end

        // A struck defender aborts to IDLE regardless of what its own FSM wanted.
        if (ryu_struck) begin
            ryu_phase_d = PHASE_IDLE;
        end else begin
            ryu_phase_d = step_phase(ryu_phase_q, ryu_trig && ryu_kb_q == '0);
        end
        if (akuma_struck) begin
            akuma_phase_d = PHASE_IDLE;
        end else begin
            akuma_phase_d = step_phase(akuma_phase_q, akuma_trig && akuma_kb_q == '0);
        end

        if (ryu_phase_q.state == ST_IDLE && ryu_phase_d.state == ST_STARTUP) begin
            ryu_conn_d = 1'b0;
        end else if (akuma_struck) begin
            ryu_conn_d = 1'b1;
        end
        if (akuma_phase_q.state == ST_IDLE && akuma_phase_d.state == ST_STARTUP) begin
            akuma_conn_d = 1'b0;
        end else if (ryu_struck) begin
            akuma_conn_d = 1'b1;
        end

        ryu_kb_d   = step_kb(ryu_kb_q, ryu_struck);
        akuma_kb_d = step_kb(akuma_kb_q, akuma_struck);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            XDist           <= INIT_DIST;
            Ryu_Knockback   <= 0;
            Akuma_Knockback <= 0;
            RyuHit          <= 1'b0;
            AkumaHit        <= 1'b0;
            ryu_phase_q     <= PHASE_IDLE;
            akuma_phase_q   <= PHASE_IDLE;
            ryu_kb_q        <= '0;
            akuma_kb_q      <= '0;
            ryu_conn_q      <= 1'b0;
            akuma_conn_q    <= 1'b0;
            ryu_pressed_q   <= 1'b0;
            akuma_pressed_q <= 1'b0;
        end else begin
            XDist           <= int'(AkumaX) - int'(RyuX);
            Ryu_Knockback   <= (ryu_kb_q != '0 && !ryu_clamp) ? -KB_SPEED : 0;
            Akuma_Knockback <= (akuma_kb_q != '0 && !akuma_clamp) ? KB_SPEED : 0;
            RyuHit          <= ryu_struck;
            AkumaHit        <= akuma_struck;
            ryu_phase_q     <= ryu_phase_d;
            akuma_phase_q   <= akuma_phase_d;
            ryu_kb_q        <= ryu_kb_d;
            akuma_kb_q      <= akuma_kb_d;
            ryu_conn_q      <= ryu_conn_d;
            akuma_conn_q    <= akuma_conn_d;
            ryu_pressed_q   <= ryu_pressed;
            akuma_pressed_q <= akuma_pressed;
        end
    end

    assign RyuAtkActive   = (ryu_phase_q.state == ST_ACTIVE);
    assign AkumaAtkActive = (akuma_phase_q.state == ST_ACTIVE);

endmodule

// File: tb/tb_knockback_unit.sv
// Directed bench for knockback_unit: attack timing, hits, trades, hitstun, clamping and reset.
// Each frame packs {RyuAtkActive, AkumaAtkActive, RyuHit, AkumaHit, Ryu_KB, Akuma_KB} for comparison.
module tb_knockback_unit;

    logic       frame_clk = 1'b0;
    logic       Reset;
    logic [7:0] keycode_0, keycode_1, keycode_2, keycode_3;
    logic [9:0] RyuX, AkumaX;
    logic       RyuJump, AkumaJump;
    int         XDist, Ryu_Knockback, Akuma_Knockback;
    logic       RyuHit, AkumaHit, RyuAtkActive, AkumaAtkActive;

    int total = 0;
    int bad   = 0;

    knockback_unit dut (
        .frame_clk      (frame_clk),
        .Reset          (Reset),
        .keycode_0      (keycode_0),
        .keycode_1      (keycode_1),
        .keycode_2      (keycode_2),
        .keycode_3      (keycode_3),
        .RyuX           (RyuX),
        .AkumaX         (AkumaX),
        .RyuJump        (RyuJump),
        .AkumaJump      (AkumaJump),
        .XDist          (XDist),
        .Ryu_Knockback  (Ryu_Knockback),
        .Akuma_Knockback(Akuma_Knockback),
        .RyuHit         (RyuHit),
        .AkumaHit       (AkumaHit),
        .RyuAtkActive   (RyuAtkActive),
        .AkumaAtkActive (AkumaAtkActive)
    );

    always #5 frame_clk = ~frame_clk;

    task automatic tick();
        @(posedge frame_clk);
        #1;
    endtask

    // Reset, then one frame with the given positions so XDist is loaded.
    task automatic apply_reset(input logic [9:0] rx, input logic [9:0] ax);
        Reset     = 1'b1;
        keycode_0 = 8'h00;
        keycode_1 = 8'h00;
        keycode_2 = 8'h00;
        keycode_3 = 8'h00;
        RyuJump   = 1'b0;
        AkumaJump = 1'b0;
        RyuX      = rx;
        AkumaX    = ax;
        tick();
        tick();
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [67:0] got, want;
        Reset     = 1'b1;
        keycode_0 = 8'h00;
        keycode_1 = 8'h00;
        keycode_2 = 8'h00;
        keycode_3 = 8'h00;
        RyuJump   = 1'b0;
        AkumaJump = 1'b0;
        RyuX      = 10'd200;
        AkumaX    = 10'd300;
        #2;
        total++;
        if (XDist !== 320) begin
            bad++;
            $display("FAIL reset_xdist got=%0d want=320", XDist);
        end
        got  = {RyuAtkActive, AkumaAtkActive, RyuHit, AkumaHit, Ryu_Knockback, Akuma_Knockback};
        want = '0;
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", got, want);
        end
        tick();
        Reset = 1'b0;
        tick();
        total++;
        if (XDist !== 100) begin
            bad++;
            $display("FAIL xdist_pos got=%0d want=100", XDist);
        end
        RyuX   = 10'd300;
        AkumaX = 10'd200;
        tick();
        total++;
        if (XDist !== -100) begin
            bad++;
            $display("FAIL xdist_neg got=%0d want=-100", XDist);
        end
    endtask

    // Ryu hits Akuma; key held 20 frames must not retrigger.
    task automatic test_hit_and_hold();
        logic [67:0] got, want;
        apply_reset(10'd200, 10'd300);
        for (int f = 0; f <= 20; f++) begin
            if (f == 0) keycode_2 = 8'h09;
            tick();
            got  = {RyuAtkActive, AkumaAtkActive, RyuHit, AkumaHit, Ryu_Knockback, Akuma_Knockback};
            want = {(f >= 4 && f <= 6), 1'b0, 1'b0, (f == 5), 32'sd0,
                    ((f >= 6 && f <= 13) ? 32'sd3 : 32'sd0)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL hit_and_hold f=%0d got=%h want=%h", f, got, want);
            end
        end
    endtask

    // Attack completes but Akuma is either out of range or airborne.
    task automatic test_no_hit(input logic [9:0] ax, input logic jump, input string name);
        logic [67:0] got, want;
        apply_reset(10'd200, ax);
        AkumaJump = jump;
        for (int f = 0; f <= 16; f++) begin
            if (f == 0) keycode_0 = 8'h09;
            tick();
            got  = {RyuAtkActive, AkumaAtkActive, RyuHit, AkumaHit, Ryu_Knockback, Akuma_Knockback};
            want = {(f >= 4 && f <= 6), 1'b0, 1'b0, 1'b0, 32'sd0, 32'sd0};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL %s f=%0d got=%h want=%h", name, f, got, want);
            end
        end
    endtask

    task automatic test_trade();
        logic [67:0] got, want;
        apply_reset(10'd200, 10'd300);
        for (int f = 0; f <= 16; f++) begin
            if (f == 0) begin
                keycode_0 = 8'h09;
                keycode_3 = 8'h10;
            end
            tick();
            got  = {RyuAtkActive, AkumaAtkActive, RyuHit, AkumaHit, Ryu_Knockback, Akuma_Knockback};
            want = {(f == 4), (f == 4), (f == 5), (f == 5),
                    ((f >= 6 && f <= 13) ? -32'sd3 : 32'sd0),
                    ((f >= 6 && f <= 13) ? 32'sd3 : 32'sd0)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL trade f=%0d got=%h want=%h", f, got, want);
            end
        end
    endtask

    // Akuma is struck in STARTUP, presses during hitstun (ignored), then attacks afterwards.
    task automatic test_abort_and_hitstun();
        logic [67:0] got, want;
        apply_reset(10'd200, 10'd300);
        for (int f = 0; f <= 30; f++) begin
            if (f == 0) keycode_0 = 8'h09;
            if (f == 3 || f == 9 || f == 15) keycode_1 = 8'h10;
            if (f == 7 || f == 11) keycode_1 = 8'h00;
            tick();
            got  = {RyuAtkActive, AkumaAtkActive, RyuHit, AkumaHit, Ryu_Knockback, Akuma_Knockback};
            want = {(f >= 4 && f <= 6), (f >= 19 && f <= 21), (f == 20), (f == 5),
                    ((f >= 21 && f <= 28) ? -32'sd3 : 32'sd0),
                    ((f >= 6 && f <= 13) ? 32'sd3 : 32'sd0)};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL abort_hitstun f=%0d got=%h want=%h", f, got, want);
            end
        end
    endtask

    // Akuma near the right bound: velocity clamped, counter still expires; then reset mid-knockback.
    task automatic test_clamp_and_reset();
        logic [67:0] got, want;
        apply_reset(10'd400, 10'd510);
        for (int f = 0; f <= 22; f++) begin
            if (f == 0) keycode_0 = 8'h09;
            if (f == 12 || f == 14) keycode_1 = 8'h10;
            if (f == 13) keycode_1 = 8'h00;
            tick();
            got  = {RyuAtkActive, AkumaAtkActive, RyuHit, AkumaHit, Ryu_Knockback, Akuma_Knockback};
            want = {(f >= 4 && f <= 6), (f >= 18 && f <= 20), (f == 19), (f == 5),
                    ((f >= 20) ? -32'sd3 : 32'sd0), 32'sd0};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL clamp f=%0d got=%h want=%h", f, got, want);
            end
        end
        #2;
        Reset = 1'b1;
        #1;
        got  = {RyuAtkActive, AkumaAtkActive, RyuHit, AkumaHit, Ryu_Knockback, Akuma_Knockback};
        want = '0;
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL midkb_reset_outputs got=%h want=%h", got, want);
        end
        total++;
        if (XDist !== 320) begin
            bad++;
            $display("FAIL midkb_reset_xdist got=%0d want=320", XDist);
        end
        tick();
        Reset = 1'b0;
        keycode_0 = 8'h00;
        keycode_1 = 8'h00;
        tick();
        got = {RyuAtkActive, AkumaAtkActive, RyuHit, AkumaHit, Ryu_Knockback, Akuma_Knockback};
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL post_reset_idle got=%h want=%h", got, want);
        end
    endtask

    initial begin
        test_reset();
        test_hit_and_hold();
        test_no_hit(10'd400, 1'b0, "out_of_range");
        test_no_hit(10'd300, 1'b1, "defender_jump");
        test_trade();
        test_abort_and_hitstun();
        test_clamp_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
